// File: rtl/npc_ifu_pkg.sv
// rtl/npc_ifu_pkg.sv - shared state encoding and reset constants for the fetch stage
package npc_ifu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_EXEC  = 3'd4
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/ifu_perf_cnt.sv
// rtl/ifu_perf_cnt.sv - 32-bit wrapping event counter with async active-low clear
module ifu_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch stage; IFU_FETCH_PERF_EN adds perf counters
module ifu_fetch
    import npc_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        next_pc_valid,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        fetch_err
`ifdef IFU_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        ferr_q, ferr_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        ferr_d        = ferr_q;
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A misaligned PC never reaches the bus; it is reported as a faulting NOP.
                if (pc_q[1:0] != 2'b00) begin
                    instr_d = NOP_INST;
                    ferr_d  = 1'b1;
                    state_d = S_VALID;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    instr_d = mem_resp_err ? NOP_INST : mem_resp_data;
                    ferr_d  = mem_resp_err;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (next_pc_valid) begin
                    pc_d    = next_pc;
                    ferr_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign mem_req_addr = pc_q;
    assign pc           = pc_q;
    assign instruction  = instr_q;
    assign fetch_err    = ferr_q;

`ifdef IFU_FETCH_PERF_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = (state_q != S_VALID) && (state_d == S_VALID);
    assign stall_evt = ((state_q == S_REQ)  && !mem_req_ready) ||
                       ((state_q == S_WAIT) && !mem_resp_valid);

    ifu_perf_cnt u_perf_fetch (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (fetch_evt),
        .cnt_o  (perf_fetch_cnt)
    );

    ifu_perf_cnt u_perf_stall (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (stall_evt),
        .cnt_o  (perf_stall_cnt)
    );
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the next-PC selector. Owns the architectural PC register and fetches one instruction per PC over a valid/ready memory port. Presents `instruction`/`pc` to decode/execute with a valid/ready handshake. Loads the next-PC value computed downstream to start the next fetch. Multi-cycle: at most one instruction is in flight.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset.
NOP_INST, 32'h00000013, instruction word presented on a fetch fault.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
next_pc  in  32  next PC from the next-PC selector
next_pc_valid  in  1  next_pc is valid this cycle (execute complete)
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  32  fetch address; always equals pc
mem_resp_valid  in  1  read data valid
mem_resp_data  in  32  read data
mem_resp_err  in  1  bus error qualifying mem_resp_valid
inst_valid  out  1  instruction/pc valid to downstream
inst_ready  in  1  downstream accepts the instruction
instruction  out  32  fetched instruction word
pc  out  32  PC of the presented instruction
fetch_err  out  1  fault flag accompanying inst_valid

Behaviour:
- States:
  - S_IDLE: reset state.
  - S_REQ: request.
  - S_WAIT: await response.
  - S_VALID: presenting the instruction.
  - S_EXEC: await next_pc.
- Reset (rst=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC, instruction=0, fetch_err=0.
  - All outputs valid low: mem_req_valid=0, inst_valid=0.
- S_IDLE -> S_REQ unconditionally on the first clk edge with rst=1. Gives exactly one boot cycle.
- S_REQ:
  - mem_req_valid = (pc[1:0]==2'b00); mem_req_addr = pc.
  - Valid and ready high -> S_WAIT.
  - Valid held while ready low; address stable.
  - Misaligned pc: no request issued. Load instruction=NOP_INST, fetch_err=1 -> S_VALID.
- S_WAIT:
  - mem_resp_valid=1 -> instruction=mem_resp_data, fetch_err=mem_resp_err -> S_VALID.
  - If mem_resp_err=1, load NOP_INST instead of the data.
- S_VALID:
  - inst_valid=1; instruction, pc and fetch_err held stable.
  - inst_ready=1 -> S_EXEC.
  - inst_ready=0 -> stay.
- S_EXEC:
  - next_pc_valid=1 -> pc<=next_pc, fetch_err<=0 -> S_REQ.
  - instruction holds its value until the next load.
- Ignored inputs:
  - mem_resp_valid outside S_WAIT is ignored.
  - next_pc_valid outside S_EXEC is ignored; pc is unchanged.
- Memory contract: response arrives no earlier than the cycle after the request handshake.
- Minimum latency: next_pc_valid at edge t -> mem_req_valid in cycle t+1. With ready=1 and resp_valid at t+2, inst_valid at t+3.
- Decode/execute is combinational: inst_ready and next_pc_valid may both be high in the same S_VALID cycle; only inst_ready is acted upon.
- pc wraps modulo 2^32 (no saturation); next_pc=32'hFFFFFFFC is legal.
- Reset asserted mid-transaction (S_WAIT) abandons the request; a late response after reset release is ignored (state is S_IDLE/S_REQ).

Optional Feature:
- Macro: IFU_FETCH_PERF_EN.
- Defined: two extra outputs.
  - perf_fetch_cnt[31:0]: increments on each transition into S_VALID.
  - perf_stall_cnt[31:0]: increments each cycle in S_REQ with mem_req_ready=0, or in S_WAIT with mem_resp_valid=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- Package npc_ifu_pkg:
  - state encoding (S_IDLE=0, S_REQ=1, S_WAIT=2, S_VALID=3, S_EXEC=4, 3 bits);
  - RESET_PC_DEFAULT;
  - NOP_INST_DEFAULT.
- Sub-module ifu_perf_cnt: 32-bit enable-increment counter with async active-low clear, instantiated twice under IFU_FETCH_PERF_EN.

Test Plan:
- Boot:
  - Stimulus: release rst; mem_req_ready=1; resp at the next cycle with data 32'h00000297.
  - Required: mem_req_valid=1 with addr 32'h80000000 one cycle after release. inst_valid=1 with instruction=32'h00000297, pc=32'h80000000, fetch_err=0.
- Backpressure:
  - Stimulus: mem_req_ready=0 for 3 cycles; inst_ready=0 for 4 cycles.
  - Required: mem_req_addr stable; instruction/pc stable; perf_stall_cnt=3 (when enabled).
- Redirect:
  - Stimulus: in S_EXEC, next_pc_valid=1 with next_pc=32'h80000010.
  - Required: the next request address is 32'h80000010. next_pc_valid pulsed in S_WAIT has no effect.
- Faults:
  - Stimulus: next_pc=32'h80000002.
  - Required: no mem_req_valid; inst_valid with instruction=32'h00000013, fetch_err=1.
  - Stimulus: mem_resp_err=1.
  - Required: same NOP/fetch_err response.
- Reset mid-op:
  - Stimulus: assert rst in S_WAIT; a response arrives during reset.
  - Required: pc=32'h80000000, all valids 0 immediately (asynchronous); the stale response is never presented.
- Wrap:
  - Stimulus: next_pc=32'hFFFFFFFC.
  - Required: fetch issued at 32'hFFFFFFFC. perf_fetch_cnt preset via force to 32'hFFFFFFFF wraps to 0.
